// File: rtl/mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mem_arbiter
//  Purpose  : Round-robin two-requester arbiter/sequencer for MIPS_Memory;
//             turns a req/ack handshake into one-cycle MemRead/MemWrite strobes.
//  Revision : 1.0  initial release
// ============================================================================
module mips_mem_arbiter #(
    parameter int WIDTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] WrData,
    input  logic [WIDTH-1:0] RdData,
    output logic             busy,
    output logic             grant_id
);

    localparam logic [1:0] c_RD_LAT = 2'(RD_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic             r_we;
    logic [1:0]       r_wait_cnt;

    logic             w_any_req;
    logic             w_pick;
    logic             w_pick_we;
    logic [WIDTH-1:0] w_pick_addr;
    logic [WIDTH-1:0] w_pick_wdata;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        w_any_req    = req0 | req1;
        w_pick       = (req0 & req1) ? ~r_last_grant : req1;
        w_pick_we    = w_pick ? we1    : we0;
        w_pick_addr  = w_pick ? addr1  : addr0;
        w_pick_wdata = w_pick ? wdata1 : wdata0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_wait_cnt   <= 2'd0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            busy         <= 1'b0;
            grant_id     <= 1'b0;
            addr         <= '0;
            WrData       <= '0;
            rdata0       <= '0;
            rdata1       <= '0;
        end else begin
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        grant_id     <= w_pick;
                        r_last_grant <= w_pick;
                        r_we         <= w_pick_we;
                        addr         <= w_pick_addr;
                        WrData       <= w_pick_wdata;
                        MemWrite     <= w_pick_we;
                        MemRead      <= ~w_pick_we;
                        busy         <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        ack0    <= ~grant_id;
                        ack1    <= grant_id;
                        r_state <= S_RESP;
                    end else begin
                        r_wait_cnt <= c_RD_LAT;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // RdData becomes valid exactly RD_LAT cycles after the strobe.
                    if (r_wait_cnt == 2'd1) begin
                        if (grant_id) begin
                            rdata1 <= RdData;
                        end else begin
                            rdata0 <= RdData;
                        end
                        ack0    <= ~grant_id;
                        ack1    <= grant_id;
                        r_state <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_mem_arbiter
//  Purpose  : Self-checking bench for mips_mem_arbiter (RD_LAT 1 and 3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 [2], req1 [2], we0 [2], we1 [2];
    logic [31:0] a0 [2], a1 [2], wd0 [2], wd1 [2];
    logic        ack0 [2], ack1 [2], mrd [2], mwr [2], busy [2], gid [2];
    logic [31:0] rd0 [2], rd1 [2], maddr [2], mwd [2], mrdata [2];

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    logic prev_rd [2], prev_wr [2];

    // Environment: memory behind each arbiter instance
    logic [31:0] mem [2][64];
    logic [31:0] out_port [2];
    logic [31:0] pd [2][3];
    logic [2:0]  pv [2];
    logic [31:0] inport0, inport1;

    // Reference state kept by the bench
    logic [31:0] ref_mem [2][16];
    logic [31:0] ref_out [2];

    typedef struct packed {
        logic [1:0]  k;
        logic        rq;
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [3:0]  exp_lat;
    } vec_t;
    vec_t tbl [10];

    always #5 clk = ~clk;

    mips_mem_arbiter #(.WIDTH(32), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
        .addr0(a0[0]), .addr1(a1[0]), .wdata0(wd0[0]), .wdata1(wd1[0]),
        .ack0(ack0[0]), .ack1(ack1[0]), .rdata0(rd0[0]), .rdata1(rd1[0]),
        .MemRead(mrd[0]), .MemWrite(mwr[0]), .addr(maddr[0]), .WrData(mwd[0]),
        .RdData(mrdata[0]), .busy(busy[0]), .grant_id(gid[0])
    );

    mips_mem_arbiter #(.WIDTH(32), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
        .addr0(a0[1]), .addr1(a1[1]), .wdata0(wd0[1]), .wdata1(wd1[1]),
        .ack0(ack0[1]), .ack1(ack1[1]), .rdata0(rd0[1]), .rdata1(rd1[1]),
        .MemRead(mrd[1]), .MemWrite(mwr[1]), .addr(maddr[1]), .WrData(mwd[1]),
        .RdData(mrdata[1]), .busy(busy[1]), .grant_id(gid[1])
    );

    function automatic logic [31:0] env_rd(input int k, input logic [31:0] a);
        if (a == 32'hFFF8) return inport0;
        if (a == 32'hFFFC) return inport1;
        return mem[k][a[7:2]];
    endfunction

    // Read data is only presented in the exact cycle the latency allows.
    assign mrdata[0] = pv[0][0] ? pd[0][0] : 32'hBAD0BAD0;
    assign mrdata[1] = pv[1][2] ? pd[1][2] : 32'hBAD0BAD0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mwr[k]) begin
                if (maddr[k] == 32'hFFFC) out_port[k] <= mwd[k];
                else if (maddr[k] != 32'hFFF8) mem[k][maddr[k][7:2]] <= mwd[k];
            end
            pv[k]    <= {pv[k][1:0], mrd[k]};
            pd[k][0] <= mrd[k] ? env_rd(k, maddr[k]) : 32'hBAD0BAD0;
            pd[k][1] <= pd[k][0];
            pd[k][2] <= pd[k][1];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_rd(input int k, input logic [31:0] a);
        if (a == 32'hFFF8) return inport0;
        if (a == 32'hFFFC) return inport1;
        return ref_mem[k][a[5:2]];
    endfunction

    task automatic ref_wr(input int k, input logic [31:0] a, input logic [31:0] d);
        if (a == 32'hFFFC) ref_out[k] = d;
        else ref_mem[k][a[5:2]] = d;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("strobe_overlap", 32'(mrd[k] & mwr[k]), 32'd0);
                chk("rd_strobe_width", 32'(mrd[k] & prev_rd[k]), 32'd0);
                chk("wr_strobe_width", 32'(mwr[k] & prev_wr[k]), 32'd0);
                prev_rd[k] = mrd[k];
                prev_wr[k] = mwr[k];
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic single(input vec_t v, input string nm);
        int n;
        int k;
        bit got;
        k = int'(v.k);
        @(negedge clk);
        if (!v.rq) begin
            req0[k] = 1'b1; we0[k] = v.w; a0[k] = v.a; wd0[k] = v.wd;
        end else begin
            req1[k] = 1'b1; we1[k] = v.w; a1[k] = v.a; wd1[k] = v.wd;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk({nm, "_strobe"}, 32'(v.w ? mwr[k] : mrd[k]), 32'd1);
                chk({nm, "_addr"}, maddr[k], v.a);
            end
            got = v.rq ? ack1[k] : ack0[k];
        end
        chk({nm, "_lat"}, n, 32'(v.exp_lat));
        chk({nm, "_other_ack"}, 32'(v.rq ? ack0[k] : ack1[k]), 32'd0);
        if (!v.w) chk({nm, "_rdata"}, v.rq ? rd1[k] : rd0[k], v.exp_rd);
        else ref_wr(k, v.a, v.wd);
        req0[k] = 1'b0;
        req1[k] = 1'b0;
    endtask

    // Transaction-level model: each grant occupies 3 (+RD_LAT for reads) cycles.
    task automatic run_random(input int k, input int ncyc);
        int L, g_cyc, g_lat, free_at, r;
        bit lastg, pick, g_id, g_we, eb, ea, gen;
        logic [31:0] g_addr, g_wd, g_rd, ra;
        L = (k == 0) ? 1 : 3;
        g_cyc = -100; g_lat = 2; free_at = 0; lastg = 1'b1;
        g_id = 1'b0; g_we = 1'b0; g_addr = '0; g_wd = '0; g_rd = '0;
        for (int cyc = 0; cyc < ncyc + 24; cyc++) begin
            @(negedge clk);
            eb = (cyc > g_cyc) && (cyc <= g_cyc + g_lat);
            ea = (cyc == g_cyc + g_lat);
            chk("rnd_busy", 32'(busy[k]), 32'(eb));
            chk("rnd_ack0", 32'(ack0[k]), 32'(ea && !g_id));
            chk("rnd_ack1", 32'(ack1[k]), 32'(ea && g_id));
            chk("rnd_memwrite", 32'(mwr[k]), 32'(cyc == g_cyc + 1 && g_we));
            chk("rnd_memread", 32'(mrd[k]), 32'(cyc == g_cyc + 1 && !g_we));
            if (eb) begin
                chk("rnd_grant_id", 32'(gid[k]), 32'(g_id));
                chk("rnd_addr", maddr[k], g_addr);
                if (g_we) chk("rnd_wrdata", mwd[k], g_wd);
            end
            if (ea) begin
                if (!g_we) chk("rnd_rdata", g_id ? rd1[k] : rd0[k], g_rd);
                if (g_id) req1[k] = 1'b0;
                else req0[k] = 1'b0;
            end
            gen = (cyc < ncyc);
            for (int i = 0; i < 2; i++) begin
                if (gen && !(i == 0 ? req0[k] : req1[k]) && $urandom_range(0, 2) == 0) begin
                    r  = int'($urandom_range(0, 17));
                    ra = (r < 16) ? 32'(r * 4) : ((r == 16) ? 32'hFFF8 : 32'hFFFC);
                    if (i == 0) begin
                        req0[k] = 1'b1; a0[k] = ra; wd0[k] = $urandom;
                        we0[k] = (ra == 32'hFFF8) ? 1'b0 : 1'($urandom_range(0, 1));
                    end else begin
                        req1[k] = 1'b1; a1[k] = ra; wd1[k] = $urandom;
                        we1[k] = (ra == 32'hFFF8) ? 1'b0 : 1'($urandom_range(0, 1));
                    end
                end
            end
            if (cyc >= free_at && (req0[k] || req1[k])) begin
                pick   = (req0[k] && req1[k]) ? !lastg : req1[k];
                lastg  = pick;
                g_id   = pick;
                g_we   = pick ? we1[k] : we0[k];
                g_addr = pick ? a1[k] : a0[k];
                g_wd   = pick ? wd1[k] : wd0[k];
                g_cyc  = cyc;
                g_lat  = g_we ? 2 : 2 + L;
                free_at = cyc + g_lat + 1;
                if (g_we) ref_wr(k, g_addr, g_wd);
                else g_rd = ref_rd(k, g_addr);
            end
        end
        chk("rnd_drain", 32'(req0[k] | req1[k] | busy[k]), 32'd0);
        chk("rnd_out_port", out_port[k], ref_out[k]);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int idx;
        inport0 = 32'h0001_0000;
        inport1 = 32'h0000_2222;
        for (int k = 0; k < 2; k++) begin
            req0[k] = 0; req1[k] = 0; we0[k] = 0; we1[k] = 0;
            a0[k] = '0; a1[k] = '0; wd0[k] = '0; wd1[k] = '0;
            prev_rd[k] = 0; prev_wr[k] = 0; pv[k] = '0;
            out_port[k] = '0; ref_out[k] = '0;
            for (int j = 0; j < 3; j++) pd[k][j] = '0;
            for (int j = 0; j < 64; j++) mem[k][j] = '0;
            for (int j = 0; j < 16; j++) ref_mem[k][j] = '0;
        end

        //          k     rq    w     addr          wdata         exp_rdata     lat
        tbl[0] = '{2'd0, 1'b0, 1'b1, 32'h0000_0000, 32'h0A0A_0A0A, 32'h0,         4'd2};
        tbl[1] = '{2'd0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0A0A_0A0A, 4'd3};
        tbl[2] = '{2'd0, 1'b0, 1'b1, 32'h0000_0004, 32'hF0F0_F0F0, 32'h0,         4'd2};
        tbl[3] = '{2'd0, 1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'hF0F0_F0F0, 4'd3};
        tbl[4] = '{2'd0, 1'b0, 1'b0, 32'h0000_FFF8, 32'h0,         32'h0001_0000, 4'd3};
        tbl[5] = '{2'd0, 1'b1, 1'b1, 32'h0000_FFFC, 32'h0000_1111, 32'h0,         4'd2};
        tbl[6] = '{2'd0, 1'b1, 1'b0, 32'h0000_FFFC, 32'h0,         32'h0000_2222, 4'd3};
        tbl[7] = '{2'd1, 1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 32'h0,         4'd2};
        tbl[8] = '{2'd1, 1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h1234_5678, 4'd5};
        tbl[9] = '{2'd1, 1'b0, 1'b0, 32'h0000_FFF8, 32'h0,         32'h0001_0000, 4'd5};

        do_reset();
        for (int k = 0; k < 2; k++) begin
            chk("rst_ack0", 32'(ack0[k]), 32'd0);
            chk("rst_ack1", 32'(ack1[k]), 32'd0);
            chk("rst_busy", 32'(busy[k]), 32'd0);
            chk("rst_grant_id", 32'(gid[k]), 32'd0);
            chk("rst_strobes", 32'({mrd[k], mwr[k]}), 32'd0);
            chk("rst_addr", maddr[k], 32'd0);
            chk("rst_wrdata", mwd[k], 32'd0);
            chk("rst_rdata0", rd0[k], 32'd0);
            chk("rst_rdata1", rd1[k], 32'd0);
        end
        mon_en = 1'b1;

        for (int i = 0; i < 10; i++) single(tbl[i], $sformatf("vec%0d", i));
        @(negedge clk);
        chk("output_port", out_port[0], 32'h0000_1111);

        // Tie from reset: strict alternation starting with requester 0
        do_reset();
        req0[0] = 1; we0[0] = 0; a0[0] = 32'h4;
        req1[0] = 1; we1[0] = 0; a1[0] = 32'h4;
        n = 0; idx = 0;
        while (idx < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (ack0[0] || ack1[0]) begin
                chk("tie_order", 32'(ack1[0]), 32'(idx % 2));
                chk("tie_single_ack", 32'(ack0[0] & ack1[0]), 32'd0);
                chk("tie_rdata", ack1[0] ? rd1[0] : rd0[0], 32'hF0F0_F0F0);
                idx++;
            end
        end
        chk("tie_done", idx, 32'd4);
        req0[0] = 0; req1[0] = 0;

        // Reset in the WAIT cycle of a read
        @(negedge clk);
        @(negedge clk);
        req0[0] = 1; we0[0] = 0; a0[0] = 32'h4;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        req0[0] = 0;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_rdata0", rd0[0], 32'd0);
        chk("midrst_ack0", 32'(ack0[0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_ack", 32'(ack0[0] | ack1[0]), 32'd0);
        end
        req0[0] = 1; we0[0] = 1; a0[0] = 32'h10; wd0[0] = 32'h1111_1111;
        req1[0] = 1; we1[0] = 1; a1[0] = 32'h14; wd1[0] = 32'h2222_2222;
        n = 0; idx = 0;
        while (idx < 2 && n < 30) begin
            @(negedge clk);
            n++;
            if (ack0[0] || ack1[0]) begin
                chk("midrst_tie_order", 32'(ack1[0]), 32'(idx));
                if (ack0[0]) req0[0] = 0;
                if (ack1[0]) req1[0] = 0;
                idx++;
            end
        end
        chk("midrst_tie_done", idx, 32'd2);
        req0[0] = 0; req1[0] = 0;
        ref_wr(0, 32'h10, 32'h1111_1111);
        ref_wr(0, 32'h14, 32'h2222_2222);

        do_reset();
        run_random(0, 400);
        do_reset();
        run_random(1, 400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
